// File: rtl/dist_ascii_tx_if.sv
// dist_ascii_tx_if: report request, status and UART byte handshake for dist_ascii_tx
interface dist_ascii_tx_if;
  logic       report;
  logic [8:0] distance;
  logic       tx_done;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;
  modport master (input report, distance, tx_done, output start, tx_data, busy, frame_done);
  modport slave (output report, distance, tx_done, input start, tx_data, busy, frame_done);
endinterface

// File: rtl/dist_ascii_tx.sv
// dist_ascii_tx: clamps a distance, converts it to BCD and sends "ddd" "cm" CR LF to a UART; DIST_TX_LZ_SUPPRESS_EN blanks leading zeros
module dist_ascii_tx #(
  parameter int MAX_DIST = 400
) (
  input logic clk,
  input logic reset,
  dist_ascii_tx_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, SEND = 2'd2, WAIT = 2'd3;
  localparam logic [8:0] CLAMP = 9'(MAX_DIST);
  logic [1:0] state;
  logic [8:0] bin;
  logic [11:0] bcd, adj;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [7:0] hund, tens, ones, byte_val;
  function automatic logic [3:0] fix(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
  assign adj = {fix(bcd[11:8]), fix(bcd[7:4]), fix(bcd[3:0])};
  assign ones = {4'h3, bcd[3:0]};
`ifdef DIST_TX_LZ_SUPPRESS_EN
  assign hund = bcd[11:8] == 4'd0 ? 8'h20 : {4'h3, bcd[11:8]};
  assign tens = bcd[11:4] == 8'd0 ? 8'h20 : {4'h3, bcd[7:4]};
`else
  assign hund = {4'h3, bcd[11:8]};
  assign tens = {4'h3, bcd[7:4]};
`endif
  // select the frame byte for the current index
  always_comb begin
    byte_val = idx == 3'd0 ? hund :
               idx == 3'd1 ? tens :
               idx == 3'd2 ? ones :
               idx == 3'd3 ? 8'h63 :
               idx == 3'd4 ? 8'h6D :
               idx == 3'd5 ? 8'h0D : 8'h0A;
  end
  assign bus.start = state == SEND;
  assign bus.tx_data = (state == SEND || state == WAIT) ? byte_val : 8'h00;
  assign bus.busy = state != IDLE;
  assign bus.frame_done = state == WAIT && bus.tx_done && idx == 3'd6;
  // frame sequencer with one double-dabble step per CONV cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: if (bus.report) begin
          bin <= bus.distance > CLAMP ? CLAMP : bus.distance;
          bcd <= '0;
          cnt <= '0;
          idx <= '0;
          state <= CONV;
        end
        CONV: begin
          {bcd, bin} <= {adj[10:0], bin, 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) state <= SEND;
        end
        SEND: state <= WAIT;
        default: if (bus.tx_done) begin
          idx <= idx == 3'd6 ? 3'd0 : idx + 3'd1;
          state <= idx == 3'd6 ? IDLE : SEND;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dist_ascii_tx.sv
// tb_dist_ascii_tx: directed frames with a byte scoreboard checked by an independent monitor
module tb_dist_ascii_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  logic [7:0] q[$];
  dist_ascii_tx_if bus();
  dist_ascii_tx #(.MAX_DIST(400)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // monitor: every start pulse must match the next expected byte
  always @(negedge clk) begin
    if (bus.frame_done) fd_count++;
    if (reset && bus.start) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: tx_data=%0h with no byte expected", bus.tx_data);
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        if (bus.tx_data !== e) begin
          errors++;
          $display("FAIL byte: tx_data=%0h expected %0h", bus.tx_data, e);
        end
      end
    end
  end
  task automatic wait_start(input int n0, output int n, output bit ok);
    n = n0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic do_frame(input logic [8:0] d, input logic [7:0] h, input logic [7:0] t, input logic [7:0] o,
                          input int rpt_b, input int rst_b, input bit spur);
    int n, fd0;
    bit ok;
    logic [7:0] cap;
    q.push_back(h); q.push_back(t); q.push_back(o);
    q.push_back(8'h63); q.push_back(8'h6D); q.push_back(8'h0D); q.push_back(8'h0A);
    fd0 = fd_count;
    @(posedge clk); #1 bus.report = 1'b1; bus.distance = d;
    @(posedge clk); #1 bus.report = 1'b0; bus.distance = 9'd0;
    @(negedge clk);
    chk("busy_after_report", 32'(bus.busy), 32'd1);
    for (int b = 0; b < 7; b++) begin
      wait_start(b == 0 ? 1 : 0, n, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL start_timeout: byte %0d never started, expected a start pulse", b);
        q.delete();
        return;
      end
      if (b == 0) chk("start_latency", 32'(n), 32'd10);
      cap = bus.tx_data;
      if (spur) bus.tx_done = 1'b1;
      @(posedge clk); #1 bus.tx_done = 1'b0;
      if (b == rst_b) begin
        reset = 1'b0;
        #1;
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
        q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        return;
      end
      repeat (2) @(posedge clk);
      #1 bus.tx_done = 1'b1;
      if (b == rpt_b) begin
        bus.report = 1'b1;
        bus.distance = 9'd50;
      end
      @(negedge clk);
      chk("tx_data_stable", 32'(bus.tx_data), 32'(cap));
      @(posedge clk); #1 bus.tx_done = 1'b0; bus.report = 1'b0;
    end
    @(negedge clk);
    chk("busy_after_frame", 32'(bus.busy), 32'd0);
    chk("frame_done_count", 32'(fd_count - fd0), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask
  initial begin
    bus.report = 1'b0;
    bus.distance = 9'd0;
    bus.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_start", 32'(bus.start), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_tx_data", 32'(bus.tx_data), 32'h00);
    chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1 bus.tx_done = 1'b1;
    @(negedge clk);
    chk("idle_tx_done_frame_done", 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1 bus.tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_tx_done_busy", 32'(bus.busy), 32'd0);
    do_frame(9'd123, 8'h31, 8'h32, 8'h33, -1, -1, 1'b0);
`ifdef DIST_TX_LZ_SUPPRESS_EN
    do_frame(9'd7, 8'h20, 8'h20, 8'h37, -1, -1, 1'b0);
    do_frame(9'd0, 8'h20, 8'h20, 8'h30, -1, -1, 1'b0);
`else
    do_frame(9'd7, 8'h30, 8'h30, 8'h37, -1, -1, 1'b0);
    do_frame(9'd0, 8'h30, 8'h30, 8'h30, -1, -1, 1'b0);
`endif
    do_frame(9'd511, 8'h34, 8'h30, 8'h30, 6, -1, 1'b0);
    do_frame(9'd400, 8'h34, 8'h30, 8'h30, -1, -1, 1'b0);
    do_frame(9'd250, 8'h32, 8'h35, 8'h30, -1, -1, 1'b1);
    do_frame(9'd123, 8'h31, 8'h32, 8'h33, 2, -1, 1'b0);
    repeat (20) @(posedge clk);
    do_frame(9'd123, 8'h31, 8'h32, 8'h33, -1, 4, 1'b0);
    repeat (20) @(negedge clk);
    chk("post_reset_idle_busy", 32'(bus.busy), 32'd0);
`ifdef DIST_TX_LZ_SUPPRESS_EN
    do_frame(9'd42, 8'h20, 8'h34, 8'h32, -1, -1, 1'b0);
`else
    do_frame(9'd42, 8'h30, 8'h34, 8'h32, -1, -1, 1'b0);
`endif
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
